// File: rtl/conv3x3_sequencer.sv
// Frame sequencer for a 3x3 systolic convolution array: loads the kernel, streams
// 3-pixel columns band by band from the line buffer and tags each result window.
module conv3x3_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [9*DATA_WIDTH-1:0]     weights_in,
  output logic                        busy,
  output logic                        done,
  output logic                        load_weight,
  output logic [9*DATA_WIDTH-1:0]     filter_weights,
  output logic                        mem_rd_en,
  output logic [IDX_W-1:0]            mem_row,
  output logic [IDX_W-1:0]            mem_col,
  input  logic [3*DATA_WIDTH-1:0]     mem_rdata,
  output logic [3*DATA_WIDTH-1:0]     input_col,
  input  logic [2*DATA_WIDTH+3:0]     conv_out,
  output logic                        out_valid,
  output logic [2*DATA_WIDTH+3:0]     out_data,
  output logic [IDX_W-1:0]            out_row,
  output logic [IDX_W-1:0]            out_col
);

  localparam int unsigned WGT_W = 9 * DATA_WIDTH;
  localparam int unsigned TAG_D = PIPE_LAT + 1;
  localparam int unsigned DRN_W = $clog2(PIPE_LAT + 1) + 1;
  localparam logic [IDX_W-1:0] LAST_COL   = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(IMG_H - 3);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(PIPE_LAT);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] c;
  } tag_t;

  state_e           state_q, state_d;
  logic [WGT_W-1:0] fw_q, fw_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             busy_q, busy_d, done_q, done_d, load_q, load_d, rd_en_q, rd_en_d;
  tag_t             tag_q [TAG_D];
  tag_t             tag_d [TAG_D];

  // Next state, address walk and registered output decode
  always_comb begin
    state_d = state_q;
    fw_d    = fw_q;
    row_d   = row_q;
    col_d   = col_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          fw_d    = weights_in;
        end
      end
      LOAD_W: begin
        state_d = STREAM;
        row_d   = '0;
        col_d   = '0;
      end
      STREAM: begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            state_d = DRAIN;
            row_d   = '0;
            drn_d   = '0;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end else begin
          col_d = col_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DRAIN_LAST) state_d = DONE;
        else                     drn_d   = drn_q + DRN_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == LOAD_W) || (state_d == STREAM) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
    load_d  = (state_d == LOAD_W);
    rd_en_d = (state_d == STREAM);
  end

  // Window tags travel alongside the array latency; the first two columns of a
  // band still hold the previous band's pixels, so they are marked invalid.
  always_comb begin
    tag_d[0].v = rd_en_q && (col_q >= IDX_W'(2));
    tag_d[0].r = row_q;
    tag_d[0].c = col_q - IDX_W'(2);
    for (int i = 1; i < int'(TAG_D); i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fw_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      rd_en_q <= 1'b0;
      for (int i = 0; i < int'(TAG_D); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fw_q    <= fw_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drn_q   <= drn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      rd_en_q <= rd_en_d;
      for (int i = 0; i < int'(TAG_D); i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign load_weight    = load_q;
  assign filter_weights = fw_q;
  assign mem_rd_en      = rd_en_q;
  assign mem_row        = row_q;
  assign mem_col        = col_q;
  assign input_col      = mem_rdata;
  assign out_valid      = tag_q[TAG_D-1].v;
  assign out_row        = tag_q[TAG_D-1].r;
  assign out_col        = tag_q[TAG_D-1].c;
  assign out_data       = conv_out;

endmodule
